ihadamard_8x8_recon: RTL and testbench

//  8x8 inverse Hadamard transform for the SATD datapath: the reverse direction of the

---
 rtl/ihadamard_8x8_recon.sv | 93 +++++++++
 tb/tb_ihadamard_8x8_recon.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ihadamard_8x8_recon.sv
// ihadamard_8x8_recon: 8x8 inverse Hadamard transform.
// Coefficient rows go in, rounded and saturated residual columns come out.
module ihadamard_8x8_recon #(
    parameter int CW    = 16,
    parameter int RW    = 9,
    parameter int SHIFT = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [8*CW-1:0] in_row,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [8*RW-1:0] out_col,
    output logic [2:0]      out_idx,
    output logic            out_sat,
    output logic            busy
);
    localparam int BW = CW + 3;
    // One bit wider than the CW+6 column sum so the rounding add cannot wrap.
    localparam int ZW = CW + 7;
    localparam logic signed [ZW-1:0] RND  = ZW'(1 << (SHIFT - 1));
    localparam logic signed [ZW-1:0] MAXV = ZW'((1 << (RW - 1)) - 1);
    localparam logic signed [ZW-1:0] MINV = -MAXV - ZW'(1);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t               state;
    logic [2:0]           row_cnt, col_cnt;
    logic signed [BW-1:0] mem   [8][8];
    logic signed [CW-1:0] x     [8];
    logic signed [BW-1:0] row_t [8];
    logic signed [ZW-1:0] z     [8];
    logic signed [ZW-1:0] q     [8];
    logic [7:0]           sat_hi, sat_lo;
    logic [8*RW-1:0]      res;

    assign in_ready  = state == FILL;
    assign out_valid = state == DRAIN;
    assign busy      = state == DRAIN || row_cnt != 3'd0;
    assign out_idx   = col_cnt;
    assign out_col   = out_valid ? res : '0;
    assign out_sat   = out_valid && |(sat_hi | sat_lo);

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            x[k]     = in_row[k*CW +: CW];
            row_t[k] = '0;
        end
        for (int k = 0; k < 8; k++)
            for (int n = 0; n < 8; n++)
                row_t[k] = ^(3'(k) & 3'(n)) ? row_t[k] - BW'(x[n]) : row_t[k] + BW'(x[n]);
    end

    always_comb begin
        res    = '0;
        sat_hi = '0;
        sat_lo = '0;
        for (int i = 0; i < 8; i++) begin
            z[i] = '0;
            for (int r = 0; r < 8; r++)
                z[i] = ^(3'(i) & 3'(r)) ? z[i] - ZW'(mem[r][col_cnt]) : z[i] + ZW'(mem[r][col_cnt]);
            q[i]      = (z[i] + RND) >>> SHIFT;
            sat_hi[i] = q[i] > MAXV;
            sat_lo[i] = q[i] < MINV;
            res[i*RW +: RW] = sat_hi[i] ? MAXV[RW-1:0] : sat_lo[i] ? MINV[RW-1:0] : q[i][RW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FILL;
            row_cnt <= '0;
            col_cnt <= '0;
            for (int r = 0; r < 8; r++)
                for (int k = 0; k < 8; k++)
                    mem[r][k] <= '0;
        end else if (state == FILL) begin
            if (in_valid) begin
                for (int k = 0; k < 8; k++)
                    mem[row_cnt][k] <= row_t[k];
                row_cnt <= row_cnt + 3'd1;
                if (row_cnt == 3'd7)
                    state <= DRAIN;
            end
        end else if (out_ready) begin
            col_cnt <= col_cnt + 3'd1;
            if (col_cnt == 3'd7)
                state <= FILL;
        end
    end
endmodule

// File: tb/tb_ihadamard_8x8_recon.sv
// tb_ihadamard_8x8_recon: scoreboard bench for the 8x8 inverse Hadamard block.
// Expected columns are queued when a block is driven and popped as columns drain.
module tb_ihadamard_8x8_recon;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_row = '0;
    logic         in_ready, out_valid, out_sat, busy;
    logic [71:0]  out_col;
    logic [2:0]   out_idx;

    int n_tests = 0;
    int n_fail  = 0;
    int blk [8][8];
    int xr  [8][8];
    logic [71:0] q_col [$];
    logic        q_sat [$];
    int          q_idx [$];

    always #5 clk = ~clk;

    ihadamard_8x8_recon dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_row(in_row), .out_valid(out_valid), .out_ready(out_ready),
        .out_col(out_col), .out_idx(out_idx), .out_sat(out_sat), .busy(busy)
    );

    function automatic int hs(int a, int b);
        return ($countones(a & b) % 2) ? -1 : 1;
    endfunction

    task automatic clear_blk();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                blk[r][c] = 0;
    endtask

    task automatic flush_q();
        q_col.delete();
        q_sat.delete();
        q_idx.delete();
    endtask

    // Reference: direct double sum of H*C*H, round half up, saturate.
    task automatic push_model();
        logic [71:0] col;
        logic        sat;
        int          z, v;
        for (int j = 0; j < 8; j++) begin
            col = '0;
            sat = 1'b0;
            for (int i = 0; i < 8; i++) begin
                z = 0;
                for (int r = 0; r < 8; r++)
                    for (int n = 0; n < 8; n++)
                        z += hs(i, r) * blk[r][n] * hs(n, j);
                v = (z + 32) >>> 6;
                if (v > 255) begin v = 255; sat = 1'b1; end
                else if (v < -256) begin v = -256; sat = 1'b1; end
                col[i*9 +: 9] = 9'(v);
            end
            q_col.push_back(col);
            q_sat.push_back(sat);
            q_idx.push_back(j);
        end
    endtask

    task automatic push_xr(input logic sat);
        logic [71:0] col;
        for (int j = 0; j < 8; j++) begin
            col = '0;
            for (int i = 0; i < 8; i++)
                col[i*9 +: 9] = 9'(xr[i][j]);
            q_col.push_back(col);
            q_sat.push_back(sat);
            q_idx.push_back(j);
        end
    endtask

    task automatic fill_xr(input int v);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                xr[i][j] = v;
    endtask

    task automatic drive(input int nrows, input int gap_pct);
        int t, v;
        for (int r = 0; r < nrows; r++) begin
            while ($urandom_range(99) < 32'(gap_pct)) begin
                in_valid = 1'b0;
                in_row   = {4{$urandom()}};
                @(negedge clk);
            end
            in_valid = 1'b1;
            for (int n = 0; n < 8; n++) begin
                v = blk[r][n];
                in_row[n*16 +: 16] = v[15:0];
            end
            t = 0;
            while (!in_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            n_tests++;
            if (t >= 50) begin
                n_fail++;
                $display("FAIL row_accept_timeout row=%0d in_ready=%b required=1", r, in_ready);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (nrows == 8) begin
            n_tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL first_col_latency out_valid=%b in_ready=%b busy=%b required 1/0/1",
                         out_valid, in_ready, busy);
            end
        end
    endtask

    task automatic drain(input int ncols, input int stall_pct, input bit stall_last, input bit junk);
        int  done, t, hold;
        bit  stall;
        done = 0; t = 0; hold = 0;
        while (done < ncols && t < 400) begin
            stall = $urandom_range(99) < 32'(stall_pct);
            if (stall_last && out_idx == 3'd7 && hold < 3) begin
                stall = 1'b1;
                hold++;
            end
            out_ready = !stall;
            if (junk) begin
                in_valid = 1'($urandom_range(1));
                in_row   = {4{$urandom()}};
            end
            n_tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL drain_flags out_valid=%b in_ready=%b busy=%b required 1/0/1",
                         out_valid, in_ready, busy);
            end else if (q_col.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty out_idx=%0d required no output", out_idx);
            end else begin
                if (out_col !== q_col[0] || out_idx !== 3'(q_idx[0]) || out_sat !== q_sat[0]) begin
                    n_fail++;
                    $display("FAIL column idx=%0d sat=%b col=%h required idx=%0d sat=%b col=%h",
                             out_idx, out_sat, out_col, q_idx[0], q_sat[0], q_col[0]);
                end
                if (!stall) begin
                    void'(q_col.pop_front());
                    void'(q_sat.pop_front());
                    void'(q_idx.pop_front());
                    done++;
                end
            end
            @(negedge clk);
            in_valid = 1'b0;
            t++;
        end
        out_ready = 1'b0;
        if (t >= 400) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout columns=%0d required=%0d", done, ncols);
        end
        if (ncols == 8) begin
            n_tests++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_idx !== 3'd0) begin
                n_fail++;
                $display("FAIL after_drain in_ready=%b out_valid=%b busy=%b idx=%0d required 1/0/0/0",
                         in_ready, out_valid, busy, out_idx);
            end
        end
    endtask

    task automatic run_block(input int gap, input int stall, input bit stall_last, input bit junk);
        drive(8, gap);
        drain(8, stall, stall_last, junk);
    endtask

    task automatic check_idle(input string tag);
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            out_idx !== 3'd0 || out_sat !== 1'b0 || out_col !== 72'd0) begin
            n_fail++;
            $display("FAIL %s in_ready=%b out_valid=%b busy=%b idx=%0d sat=%b col=%h required 1/0/0/0/0/0",
                     tag, in_ready, out_valid, busy, out_idx, out_sat, out_col);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset_asserted");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("reset_released");
    endtask

    task automatic test_dc();
        clear_blk();
        blk[0][0] = 64;
        fill_xr(1);
        push_xr(1'b0);
        run_block(0, 0, 0, 0);
    endtask

    task automatic test_extremes();
        int c  [6] = '{16320, -16384, 32767, 32, -32, -33};
        int v  [6] = '{255, -256, 255, 1, 0, -1};
        bit s  [6] = '{0, 0, 1, 0, 0, 0};
        for (int k = 0; k < 6; k++) begin
            clear_blk();
            blk[0][0] = c[k];
            fill_xr(v[k]);
            push_xr(s[k]);
            run_block(0, 0, 0, 0);
        end
    endtask

    task automatic test_basis();
        clear_blk();
        blk[1][0] = 64;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                xr[i][j] = (i % 2) ? -1 : 1;
        push_xr(1'b0);
        run_block(0, 0, 0, 0);
        clear_blk();
        blk[0][1] = 64;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                xr[i][j] = (j % 2) ? -1 : 1;
        push_xr(1'b0);
        run_block(0, 0, 0, 0);
    endtask

    task automatic test_round_trip();
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 8; j++)
                    xr[i][j] = int'($urandom_range(511)) - 256;
            for (int a = 0; a < 8; a++)
                for (int c = 0; c < 8; c++) begin
                    blk[a][c] = 0;
                    for (int i = 0; i < 8; i++)
                        for (int j = 0; j < 8; j++)
                            blk[a][c] += hs(a, i) * xr[i][j] * hs(j, c);
                end
            push_xr(1'b0);
            run_block(20, 20, 0, 0);
        end
    endtask

    task automatic test_handshake();
        for (int b = 0; b < 4; b++) begin
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    blk[r][c] = int'($urandom_range(65535)) - 32768;
            push_model();
            run_block(30, 35, 1, 1);
        end
    endtask

    task automatic test_back_to_back();
        for (int b = 0; b < 3; b++) begin
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    blk[r][c] = int'($urandom_range(4095)) - 2048;
            push_model();
            run_block(0, 0, 0, 0);
        end
    endtask

    task automatic test_reset_mid();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                blk[r][c] = int'($urandom_range(8191)) - 4096;
        drive(5, 0);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_partial busy=%b required=1", busy);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("reset_mid_fill");
        test_dc();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                blk[r][c] = int'($urandom_range(8191)) - 4096;
        push_model();
        drive(8, 0);
        drain(3, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        flush_q();
        @(negedge clk);
        check_idle("reset_mid_drain");
        test_basis();
    endtask

    initial begin
        test_reset();
        test_dc();
        test_extremes();
        test_basis();
        test_round_trip();
        test_handshake();
        test_back_to_back();
        test_reset_mid();
        n_tests++;
        if (q_col.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover entries=%0d required=0", q_col.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
